// File: rtl/q2_cpu_if.sv
// Q2 memory bus controls: address plus read/write strobes driven by the CPU.
// The data bus is bidirectional and stays a plain inout on the CPU.
interface q2_cpu_if;
  logic [11:0] abus;
  logic        rdm;
  logic        wrm;

  modport master (output abus, rdm, wrm);
  modport slave  (input  abus, rdm, wrm);
endinterface

// File: rtl/q2_cpu.sv
// Q2 12-bit accumulator processor: fetch/indirect/execute/store FSM with a
// halted-mode front panel for PC increment and memory deposit.
module q2_cpu (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] sw,
  input  logic        incp_sw,
  input  logic        dep_sw,
  input  logic        start_sw,
  input  logic        stop_sw,
  q2_cpu_if.master    bus,
  inout  wire  [11:0] dbus,
  output logic        run
);

  localparam int unsigned W     = 12;
  localparam int unsigned OFF_W = 7;

  localparam logic [2:0] OP_NOR = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_JC  = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE, S_F, S_I, S_E, S_S1, S_S2, S_D1, S_D2
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   pc, pc_n, acc, acc_n, ir, ir_n, ea, ea_n;
  logic           cy, cy_n;
  logic [W-1:0]   abus_q, abus_n, dout_q, dout_n;
  logic           rdm_q, rdm_n, wrm_q, wrm_n, doe_q, doe_n;
  logic           incp_d, dep_d, incp_rise, dep_rise;
  logic           hlt;
  logic [W:0]     sum;
  logic [W-1:0]   a_t;
  logic           c_t;
  logic           run_set, run_clr;
  logic           unused_ir;

  assign incp_rise = incp_sw & ~incp_d;
  assign dep_rise  = dep_sw & ~dep_d;
  assign unused_ir = ^ir[8:0];

  assign bus.abus = abus_q;
  assign bus.rdm  = rdm_q;
  assign bus.wrm  = wrm_q;
  assign dbus     = doe_q ? dout_q : {W{1'bz}};

  // Run flag: level-sensitive async set/clear from the panel, sync clear on HLT
  assign run_set = start_sw & ~rst & ~stop_sw;
  assign run_clr = rst | stop_sw;

  always_ff @(posedge clk or posedge run_clr or posedge run_set) begin
    if (run_clr)      run <= 1'b0;
    else if (run_set) run <= 1'b1;
    else if (hlt)     run <= 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= '0;
      acc    <= '0;
      cy     <= 1'b0;
      ir     <= '0;
      ea     <= '0;
      abus_q <= '0;
      dout_q <= '0;
      rdm_q  <= 1'b0;
      wrm_q  <= 1'b0;
      doe_q  <= 1'b0;
      incp_d <= 1'b0;
      dep_d  <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      acc    <= acc_n;
      cy     <= cy_n;
      ir     <= ir_n;
      ea     <= ea_n;
      abus_q <= abus_n;
      dout_q <= dout_n;
      rdm_q  <= rdm_n;
      wrm_q  <= wrm_n;
      doe_q  <= doe_n;
      incp_d <= incp_sw;
      dep_d  <= dep_sw;
    end
  end

  // Next state and datapath; OPR needs no operand so it completes in fetch
  always_comb begin
    state_n = state;
    pc_n    = pc;
    acc_n   = acc;
    cy_n    = cy;
    ir_n    = ir;
    ea_n    = ea;
    hlt     = 1'b0;
    sum     = '0;
    a_t     = acc;
    c_t     = cy;

    case (state)
      S_IDLE: begin
        if (run)            state_n = S_F;
        else if (dep_rise)  state_n = S_D1;
        else if (incp_rise) pc_n = pc + W'(1);
      end
      S_F: begin
        ir_n = dbus;
        pc_n = pc + W'(1);
        ea_n = {dbus[7] ? pc[W-1:OFF_W] : 5'b0, dbus[OFF_W-1:0]};
        if (dbus[11:9] == OP_OPR) begin
          if (dbus[0]) a_t = '0;
          if (dbus[1]) c_t = 1'b0;
          if (dbus[2]) a_t = ~a_t;
          if (dbus[3]) begin
            sum = {1'b0, a_t} + (W+1)'(1);
            a_t = sum[W-1:0];
            c_t = sum[W];
          end
          acc_n   = a_t;
          cy_n    = c_t;
          hlt     = dbus[7];
          state_n = (run && !dbus[7]) ? S_F : S_IDLE;
        end else if (dbus[8]) begin
          state_n = S_I;
        end else begin
          state_n = (dbus[11:9] == OP_STA) ? S_S1 : S_E;
        end
      end
      S_I: begin
        ea_n    = dbus;
        state_n = (ir[11:9] == OP_STA) ? S_S1 : S_E;
      end
      S_E: begin
        case (ir[11:9])
          OP_NOR: acc_n = ~(acc | dbus);
          OP_ADD: begin
            sum   = {1'b0, acc} + {1'b0, dbus};
            acc_n = sum[W-1:0];
            cy_n  = sum[W];
          end
          OP_LDA: acc_n = dbus;
          OP_JMP: pc_n = ea;
          OP_JZ:  if (acc == '0) pc_n = ea;
          OP_JC:  if (cy) pc_n = ea;
          default: ;
        endcase
        state_n = run ? S_F : S_IDLE;
      end
      S_S1: state_n = S_S2;
      S_S2: state_n = run ? S_F : S_IDLE;
      S_D1: state_n = S_D2;
      S_D2: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so they leave a flop
  always_comb begin
    abus_n = pc_n;
    rdm_n  = 1'b0;
    wrm_n  = 1'b0;
    doe_n  = 1'b0;
    dout_n = dout_q;

    case (state_n)
      S_IDLE: abus_n = pc_n;
      S_F: begin
        abus_n = pc_n;
        rdm_n  = 1'b1;
      end
      S_I: begin
        abus_n = ea_n;
        rdm_n  = 1'b1;
      end
      S_E: begin
        abus_n = ea_n;
        rdm_n  = (ir_n[11:9] == OP_NOR) || (ir_n[11:9] == OP_ADD) ||
                 (ir_n[11:9] == OP_LDA);
      end
      S_S1: begin
        abus_n = ea_n;
        doe_n  = 1'b1;
        dout_n = acc_n;
      end
      S_D1: begin
        abus_n = pc_n;
        doe_n  = 1'b1;
        dout_n = sw;
      end
      S_S2, S_D2: begin
        abus_n = abus_q;
        doe_n  = 1'b1;
        wrm_n  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_q2_cpu.sv
// Self-checking bench for q2_cpu: 4Kx12 memory model, write scoreboard and
// directed programs for load, indirect store, carry/branch, OPR and panel.
module tb_q2_cpu;

  logic        clk;
  logic        rst;
  logic [11:0] sw;
  logic        incp_sw, dep_sw, start_sw, stop_sw;
  wire  [11:0] dbus;
  logic        run;

  q2_cpu_if bus ();

  q2_cpu dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .incp_sw  (incp_sw),
    .dep_sw   (dep_sw),
    .start_sw (start_sw),
    .stop_sw  (stop_sw),
    .bus      (bus),
    .dbus     (dbus),
    .run      (run)
  );

  logic [11:0] mem [4096];
  logic [23:0] exp_q [$];
  logic [23:0] obs_q [$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          excl_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dbus = bus.rdm ? mem[bus.abus] : 12'bz;

  // Memory captures on the write strobe; every write is logged for the scoreboard
  always @(posedge bus.wrm) begin
    mem[bus.abus] = dbus;
    obs_q.push_back({bus.abus, dbus});
  end

  always @(negedge clk) if (bus.rdm && bus.wrm) excl_bad++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 12'hE80;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk);
    start_sw = 1'b1;
    #1;
    start_sw = 1'b0;
  endtask

  // Counts clock edges after the first fetch cycle until run drops
  task automatic run_to_halt(input int maxc, output int n);
    n = 0;
    while (run && n < maxc) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic sb_drain(input string tag);
    logic [23:0] e, o;
    check({tag, "_nwr"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      check({tag, "_wr"}, 32'(o), 32'(e));
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  initial begin
    int n;
    rst = 1'b0; sw = '0; incp_sw = 0; dep_sw = 0; start_sw = 0; stop_sw = 0;

    // Reset with stop held, then async start before any clock edge
    clear_mem();
    mem[0] = 12'h402; mem[1] = 12'hE80; mem[2] = 12'h123;
    @(negedge clk);
    rst = 1'b1; stop_sw = 1'b1;
    #1;
    check("rst_abus", 32'(bus.abus), 32'h000);
    check("rst_rdm",  32'(bus.rdm), 32'd0);
    check("rst_wrm",  32'(bus.wrm), 32'd0);
    check("rst_acc",  32'(dut.acc), 32'h000);
    start_sw = 1'b1;
    #1;
    check("run_stop_dominates", 32'(run), 32'd0);
    start_sw = 1'b0; rst = 1'b0; stop_sw = 1'b0;
    #1;
    start_sw = 1'b1;
    #1;
    check("run_async_set", 32'(run), 32'd1);
    check("idle_rdm_low", 32'(bus.rdm), 32'd0);
    start_sw = 1'b0;
    @(posedge clk); #1;
    check("first_fetch_abus", 32'(bus.abus), 32'h000);
    check("first_fetch_rdm",  32'(bus.rdm), 32'd1);
    run_to_halt(100, n);
    check("lda_hlt_cycles", 32'(n), 32'd3);
    check("lda_acc", 32'(dut.acc), 32'h123);
    check("lda_halt_abus", 32'(bus.abus), 32'h002);

    // Indirect store to the output region
    clear_mem();
    mem[0] = 12'h404; mem[1] = 12'h705; mem[2] = 12'hE80;
    mem[4] = 12'h5A5; mem[5] = 12'h800;
    exp_q.push_back({12'h800, 12'h5A5});
    do_reset();
    start_pulse();
    @(posedge clk); #1;
    run_to_halt(100, n);
    check("sta_cycles", 32'(n), 32'd7);
    sb_drain("sta_ind");
    check("sta_mem800", 32'(mem[12'h800]), 32'h5A5);
    check("sta_halt_abus", 32'(bus.abus), 32'h003);

    // ADD overflow sets C; JC then JZ both taken, store marks arrival
    clear_mem();
    mem[12'h000] = 12'h420; mem[12'h001] = 12'h221; mem[12'h002] = 12'hC10;
    mem[12'h010] = 12'hA30; mem[12'h030] = 12'h640;
    mem[12'h020] = 12'hFFF; mem[12'h021] = 12'h001;
    exp_q.push_back({12'h040, 12'h000});
    do_reset();
    start_pulse();
    @(posedge clk); #1;
    run_to_halt(100, n);
    check("add_cycles", 32'(n), 32'd12);
    check("add_carry", 32'(dut.cy), 32'd1);
    check("add_acc", 32'(dut.acc), 32'h000);
    check("add_halt_abus", 32'(bus.abus), 32'h032);
    sb_drain("add_jc_jz");

    // NOR, OPR bit ordering, indirect JMP, page-relative STA, JC not taken
    clear_mem();
    mem[12'h000] = 12'h420; mem[12'h001] = 12'h021; mem[12'h002] = 12'h640;
    mem[12'h003] = 12'hE0D; mem[12'h004] = 12'h922;
    mem[12'h020] = 12'h0F0; mem[12'h021] = 12'h00F; mem[12'h022] = 12'h0A0;
    mem[12'h0A0] = 12'hE0A; mem[12'h0A1] = 12'h6C1; mem[12'h0A2] = 12'hCA5;
    mem[12'h0A5] = 12'h642;
    exp_q.push_back({12'h040, 12'hF00});
    exp_q.push_back({12'h0C1, 12'h001});
    do_reset();
    start_pulse();
    @(posedge clk); #1;
    run_to_halt(100, n);
    check("opr_cycles", 32'(n), 32'd18);
    check("opr_acc", 32'(dut.acc), 32'h001);
    check("opr_carry", 32'(dut.cy), 32'd0);
    check("opr_halt_abus", 32'(bus.abus), 32'h0A4);
    sb_drain("nor_opr");

    // Halted front panel: deposit, increment, held increment, simultaneous
    do_reset();
    sw = 12'hABC;
    exp_q.push_back({12'h000, 12'hABC});
    @(negedge clk); dep_sw = 1'b1;
    @(negedge clk); dep_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("dep_mem0", 32'(mem[0]), 32'hABC);
    check("dep_pc_kept", 32'(bus.abus), 32'h000);
    @(negedge clk); incp_sw = 1'b1;
    @(negedge clk); incp_sw = 1'b0;
    @(negedge clk);
    check("incp_once", 32'(bus.abus), 32'h001);
    incp_sw = 1'b1;
    repeat (5) @(negedge clk);
    incp_sw = 1'b0;
    @(negedge clk);
    check("incp_held", 32'(bus.abus), 32'h002);
    sw = 12'h5A5;
    exp_q.push_back({12'h002, 12'h5A5});
    dep_sw = 1'b1; incp_sw = 1'b1;
    @(negedge clk); dep_sw = 1'b0; incp_sw = 1'b0;
    repeat (3) @(negedge clk);
    check("both_pc_kept", 32'(bus.abus), 32'h002);
    check("both_mem2", 32'(mem[2]), 32'h5A5);
    check("panel_run", 32'(run), 32'd0);
    sb_drain("panel");

    // Stop during an indirect STA: store completes, then idle at next PC
    clear_mem();
    mem[0] = 12'h404; mem[1] = 12'h705; mem[2] = 12'hE80;
    mem[4] = 12'h3C3; mem[5] = 12'h810;
    exp_q.push_back({12'h810, 12'h3C3});
    do_reset();
    start_pulse();
    repeat (4) begin @(posedge clk); #1; end
    check("stop_in_indirect_abus", 32'(bus.abus), 32'h005);
    check("stop_in_indirect_rdm", 32'(bus.rdm), 32'd1);
    stop_sw = 1'b1;
    #1;
    check("stop_run_async", 32'(run), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
    check("stop_idle_abus", 32'(bus.abus), 32'h002);
    check("stop_idle_rdm", 32'(bus.rdm), 32'd0);
    check("stop_idle_wrm", 32'(bus.wrm), 32'd0);
    stop_sw = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("stop_stays_idle", 32'(bus.abus), 32'h002);
    check("stop_mem810", 32'(mem[12'h810]), 32'h3C3);
    sb_drain("stop");

    check("rdm_wrm_exclusive", 32'(excl_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
